// File: rtl/ex_mem_pipeline_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_pipeline_reg
//
// EX/MEM pipeline register. Captures the execute-stage results and the M/WB
// control bits on each rising clock edge, with stall (hold), flush (bubble
// insert) and a valid bit that follows the instruction into MEM. It also
// produces the EX/MEM-sourced forwarding selects for the ALU operands of the
// instruction currently in EX, and counts inserted bubbles.
//
// Parameters
//   DATA_W : width of AddResult / ALUResult / read_data2 paths
//   REG_W  : width of register specifiers
//
// Ports
//   clk, rst_n             : rising-edge clock, asynchronous active-low reset
//   stall, flush           : hold all state / replace incoming with a bubble
//   ex_valid               : EX stage holds a real instruction
//   AddResult, ALUResult,
//   read_data2, exeMuxRes,
//   aluZero                : EX results to be registered
//   MemRead, MemWrite,
//   Branch, RegWrite,
//   MemtoReg               : M/WB control bits from ID/EX
//   ex_rs, ex_rt           : source registers of the instruction in EX
//   *_q                    : registered copies of the above
//   mem_valid              : MEM stage holds a real instruction
//   fwd_a, fwd_b           : forward ALUResult_q to ALU operand A / B
//   bubble_count           : saturating count of bubbles since reset
// ----------------------------------------------------------------------------
module ex_mem_pipeline_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] AddResult,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [REG_W-1:0]  exeMuxRes,
    input  logic              aluZero,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    output logic [DATA_W-1:0] AddResult_q,
    output logic [DATA_W-1:0] ALUResult_q,
    output logic [DATA_W-1:0] read_data2_q,
    output logic [REG_W-1:0]  exeMuxRes_q,
    output logic              aluZero_q,
    output logic              MemRead_q,
    output logic              MemWrite_q,
    output logic              Branch_q,
    output logic              RegWrite_q,
    output logic              MemtoReg_q,
    output logic              mem_valid,
    output logic              fwd_a,
    output logic              fwd_b,
    output logic [15:0]       bubble_count
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_add_result;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_read_data2;
    logic [REG_W-1:0]  r_dst;
    logic              r_alu_zero;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_branch;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_valid;
    logic [15:0]       r_bubble_count;

    // ------------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------------
    logic w_load;          // normal capture of the EX stage this edge
    logic w_bubble;        // a bubble enters MEM this edge
    logic w_count_sat;     // bubble counter already at its ceiling

    assign w_load      = !flush && !stall;
    // A flush always inserts a bubble; a load of an invalid slot is a bubble too.
    assign w_bubble    = flush || (w_load && !ex_valid);
    assign w_count_sat = (r_bubble_count == '1);

    // ------------------------------------------------------------------------
    // Pipeline register: flush > stall > load
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_result <= '0;
            r_alu_result <= '0;
            r_read_data2 <= '0;
            r_dst        <= '0;
            r_alu_zero   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (flush) begin
            r_add_result <= '0;
            r_alu_result <= '0;
            r_read_data2 <= '0;
            r_dst        <= '0;
            r_alu_zero   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!stall) begin
            r_add_result <= AddResult;
            r_alu_result <= ALUResult;
            r_read_data2 <= read_data2;
            r_dst        <= exeMuxRes;
            r_alu_zero   <= aluZero;
            // An invalid slot must never write memory or the register file,
            // nor redirect the PC; its data fields still load.
            r_mem_read   <= MemRead  && ex_valid;
            r_mem_write  <= MemWrite && ex_valid;
            r_branch     <= Branch   && ex_valid;
            r_reg_write  <= RegWrite && ex_valid;
            r_mem_to_reg <= MemtoReg;
            r_valid      <= ex_valid;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= '0;
        end else if (w_bubble && !w_count_sat) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selects (registered state vs. current EX sources)
    // Load results are not available until MEM completes, so a pending load
    // never forwards; the hazard unit stalls for load-use instead.
    // ------------------------------------------------------------------------
    logic w_fwd_src_ok;

    assign w_fwd_src_ok = r_valid && r_reg_write && !r_mem_to_reg && (r_dst != '0);

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
        if (w_fwd_src_ok) begin
            fwd_a = (r_dst == ex_rs);
            fwd_b = (r_dst == ex_rt);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign AddResult_q  = r_add_result;
    assign ALUResult_q  = r_alu_result;
    assign read_data2_q = r_read_data2;
    assign exeMuxRes_q  = r_dst;
    assign aluZero_q    = r_alu_zero;
    assign MemRead_q    = r_mem_read;
    assign MemWrite_q   = r_mem_write;
    assign Branch_q     = r_branch;
    assign RegWrite_q   = r_reg_write;
    assign MemtoReg_q   = r_mem_to_reg;
    assign mem_valid    = r_valid;
    assign bubble_count = r_bubble_count;

endmodule
